pcileech_bringup_seq: RTL and testbench

Board-level bring-up sequencer that replaces the free-running power-on tick counter.
- Generates system reset, FT601 reset and PCIe core reset in a fixed order.
- Debounces PERST#/presence, waits for link-up with timeout and retry, and pulses a config-reload request on each successful link-up.
- Sits at top level between board pins and the com, fifo and pcie blocks; also drives the power-on blink indicator.

---
 rtl/pcileech_bringup_pkg.sv | 21 ++
 rtl/pcileech_sync2ff.sv | 23 ++
 rtl/pcileech_bringup_seq.sv | 170 +++++++++++++++++
 tb/tb_pcileech_bringup_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_bringup_pkg.sv
// Shared types for the pcileech bring-up sequencer: state encoding, synchronizer depth
// and a saturating counter helper.
package pcileech_bringup_pkg;

  typedef enum logic [2:0] {
    ST_POR        = 3'd0,
    ST_COM_UP     = 3'd1,
    ST_WAIT_PERST = 3'd2,
    ST_PCIE_RST   = 3'd3,
    ST_WAIT_LINK  = 3'd4,
    ST_RUN        = 3'd5
  } seq_state_e;

  localparam int SYNC_STAGES = 2;

  // Counters hold at all-ones instead of wrapping back into a "fresh" value.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pcileech_sync2ff.sv
// Single-bit multi-flop synchronizer for asynchronous board pins; clears to 0 on reset.
module pcileech_sync2ff
  import pcileech_bringup_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pcileech_bringup_seq.sv
// Board bring-up sequencer: POR, system/FT601 release, PERST# debounce, PCIe core reset and
// link-up wait with timeout/retry. Optional WAKE# drive is built when PCILEECH_BRINGUP_WAKE_EN is defined.
module pcileech_bringup_seq
  import pcileech_bringup_pkg::*;
#(
  parameter int unsigned PARAM_POR_CYCLES      = 64,
  parameter int unsigned PARAM_PERST_DEBOUNCE  = 1024,
  parameter int unsigned PARAM_CORE_RST_CYCLES = 16,
  parameter logic [31:0] PARAM_LINK_TIMEOUT    = 32'd50000000,
  parameter int unsigned PARAM_BLINK_BIT       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pcie_present,
  input  logic       pcie_perst_n,
  input  logic       pcie_linkup,
  output logic       rst_sys,
  output logic       ft601_rst_n,
  output logic       pcie_core_rst,
  output logic       rst_cfg_reload,
  output logic       led_pwronblink,
  output logic [2:0] seq_state,
  output logic       err_link_timeout,
  output logic       pcie_wake_n
);

  localparam logic [31:0] POR_LAST  = 32'(PARAM_POR_CYCLES - 1);
  localparam logic [31:0] DEB_LAST  = 32'(PARAM_PERST_DEBOUNCE - 1);
  localparam logic [31:0] CORE_LAST = 32'(PARAM_CORE_RST_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = PARAM_LINK_TIMEOUT - 32'd1;

  logic perst_s, present_s, perst_ok;

  seq_state_e  state_d, state_q;
  logic [31:0] cnt_d, cnt_q;
  logic [63:0] tick_d, tick_q;
  logic        rst_sys_d, rst_sys_q;
  logic        ft601_rst_n_d, ft601_rst_n_q;
  logic        core_rst_d, core_rst_q;
  logic        reload_d, reload_q;
  logic        err_d, err_q;
  logic        led_d, led_q;
  logic        wake_n_d, wake_n_q;

  pcileech_sync2ff u_sync_perst (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pcie_perst_n),
    .q     (perst_s)
  );

  pcileech_sync2ff u_sync_present (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pcie_present),
    .q     (present_s)
  );

  assign perst_ok = perst_s & present_s;

  // Loss of PERST#/presence outranks link-up, link loss and timeout once PCIe bring-up has begun.
  always_comb begin
    state_d = state_q;
    cnt_d   = sat_inc32(cnt_q);
    err_d   = err_q;
    case (state_q)
      ST_POR: begin
        if (cnt_q == POR_LAST) state_d = ST_COM_UP;
      end
      ST_COM_UP: begin
        state_d = ST_WAIT_PERST;
      end
      ST_WAIT_PERST: begin
        if (!perst_ok) cnt_d = '0;
        else if (cnt_q == DEB_LAST) state_d = ST_PCIE_RST;
      end
      ST_PCIE_RST: begin
        if (!perst_ok) state_d = ST_WAIT_PERST;
        else if (cnt_q == CORE_LAST) state_d = ST_WAIT_LINK;
      end
      ST_WAIT_LINK: begin
        if (!perst_ok) begin
          state_d = ST_WAIT_PERST;
        end else if (pcie_linkup) begin
          state_d = ST_RUN;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_PCIE_RST;
        end
      end
      ST_RUN: begin
        if (!perst_ok) state_d = ST_WAIT_PERST;
        else if (!pcie_linkup) state_d = ST_PCIE_RST;
      end
      default: begin
        state_d = ST_POR;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;

    rst_sys_d     = (state_d == ST_POR);
    ft601_rst_n_d = (state_d != ST_POR);
    core_rst_d    = !(state_d inside {ST_WAIT_LINK, ST_RUN});
    reload_d      = (state_d == ST_RUN) && (state_q != ST_RUN);

    tick_d = tick_q + 64'd1;
    led_d  = tick_d[PARAM_BLINK_BIT] & ~(|tick_d[63:PARAM_BLINK_BIT+3]);
  end

`ifdef PCILEECH_BRINGUP_WAKE_EN
  localparam logic [31:0] WAKE_LIMIT = 32'(PARAM_PERST_DEBOUNCE);

  logic [31:0] wake_cnt_d, wake_cnt_q;
  logic        wake_cond;

  assign wake_cond = (state_q == ST_WAIT_PERST) && present_s && !perst_s;

  // WAKE# is pulled only while the card has sat present-but-held-in-reset for too long.
  always_comb begin
    wake_cnt_d = wake_cond ? sat_inc32(wake_cnt_q) : '0;
    wake_n_d   = !(wake_cond && (state_d == ST_WAIT_PERST) && (wake_cnt_d > WAKE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_cnt_q <= '0;
    end else begin
      wake_cnt_q <= wake_cnt_d;
    end
  end
`else
  assign wake_n_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_POR;
      cnt_q         <= '0;
      tick_q        <= '0;
      rst_sys_q     <= 1'b1;
      ft601_rst_n_q <= 1'b0;
      core_rst_q    <= 1'b1;
      reload_q      <= 1'b0;
      err_q         <= 1'b0;
      led_q         <= 1'b0;
      wake_n_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      rst_sys_q     <= rst_sys_d;
      ft601_rst_n_q <= ft601_rst_n_d;
      core_rst_q    <= core_rst_d;
      reload_q      <= reload_d;
      err_q         <= err_d;
      led_q         <= led_d;
      wake_n_q      <= wake_n_d;
    end
  end

  assign rst_sys          = rst_sys_q;
  assign ft601_rst_n      = ft601_rst_n_q;
  assign pcie_core_rst    = core_rst_q;
  assign rst_cfg_reload   = reload_q;
  assign led_pwronblink   = led_q;
  assign seq_state        = state_q;
  assign err_link_timeout = err_q;
  assign pcie_wake_n      = wake_n_q;

endmodule

// File: tb/tb_pcileech_bringup_seq.sv
// Directed bench for pcileech_bringup_seq with short link timeout and fast blink bit;
// expects the WAKE# behaviour matching whether PCILEECH_BRINGUP_WAKE_EN is defined.
module tb_pcileech_bringup_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pcie_present = 1'b1;
  logic       pcie_perst_n = 1'b1;
  logic       pcie_linkup = 1'b0;
  logic       rst_sys, ft601_rst_n, pcie_core_rst, rst_cfg_reload;
  logic       led_pwronblink, err_link_timeout, pcie_wake_n;
  logic [2:0] seq_state;

  int num_checks = 0;
  int num_fail   = 0;

  always #5 clk = ~clk;

  pcileech_bringup_seq #(
    .PARAM_POR_CYCLES      (64),
    .PARAM_PERST_DEBOUNCE  (1024),
    .PARAM_CORE_RST_CYCLES (16),
    .PARAM_LINK_TIMEOUT    (32'd100),
    .PARAM_BLINK_BIT       (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pcie_present     (pcie_present),
    .pcie_perst_n     (pcie_perst_n),
    .pcie_linkup      (pcie_linkup),
    .rst_sys          (rst_sys),
    .ft601_rst_n      (ft601_rst_n),
    .pcie_core_rst    (pcie_core_rst),
    .rst_cfg_reload   (rst_cfg_reload),
    .led_pwronblink   (led_pwronblink),
    .seq_state        (seq_state),
    .err_link_timeout (err_link_timeout),
    .pcie_wake_n      (pcie_wake_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic perst_n, input logic present, input logic linkup);
    pcie_perst_n = perst_n;
    pcie_present = present;
    pcie_linkup  = linkup;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, 32'(seq_state), 32'd0);
    checkOutput({tag, "_rst_sys"}, 32'(rst_sys), 32'd1);
    checkOutput({tag, "_ft601"}, 32'(ft601_rst_n), 32'd0);
    checkOutput({tag, "_core_rst"}, 32'(pcie_core_rst), 32'd1);
    checkOutput({tag, "_reload"}, 32'(rst_cfg_reload), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_link_timeout), 32'd0);
    checkOutput({tag, "_led"}, 32'(led_pwronblink), 32'd0);
    checkOutput({tag, "_wake"}, 32'(pcie_wake_n), 32'd1);
  endtask

  logic wake_exp_low;

  initial begin
`ifdef PCILEECH_BRINGUP_WAKE_EN
    wake_exp_low = 1'b0;
`else
    wake_exp_low = 1'b1;
`endif
    $display("[TB] reset and power-on sequence");
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(3);
    checkResetValues("reset");
    rst_n = 1'b1;

    stepCycles(15);
    checkOutput("blink_e15", 32'(led_pwronblink), 32'd0);
    stepCycles(1);
    checkOutput("blink_e16", 32'(led_pwronblink), 32'd1);
    stepCycles(47);
    checkOutput("por_state_e63", 32'(seq_state), 32'd0);
    checkOutput("por_rst_sys_e63", 32'(rst_sys), 32'd1);
    checkOutput("por_ft601_e63", 32'(ft601_rst_n), 32'd0);
    checkOutput("blink_e63", 32'(led_pwronblink), 32'd1);
    stepCycles(1);
    checkOutput("comup_state", 32'(seq_state), 32'd1);
    checkOutput("comup_rst_sys", 32'(rst_sys), 32'd0);
    checkOutput("comup_ft601", 32'(ft601_rst_n), 32'd1);
    checkOutput("blink_e64", 32'(led_pwronblink), 32'd0);
    stepCycles(1);
    checkOutput("waitperst_state", 32'(seq_state), 32'd2);
    checkOutput("waitperst_core_rst", 32'(pcie_core_rst), 32'd1);
    stepCycles(1023);
    checkOutput("debounce_last_state", 32'(seq_state), 32'd2);
    checkOutput("blink_late", 32'(led_pwronblink), 32'd0);
    stepCycles(1);
    checkOutput("pcierst_state", 32'(seq_state), 32'd3);
    checkOutput("pcierst_core_rst", 32'(pcie_core_rst), 32'd1);
    stepCycles(15);
    checkOutput("pcierst_end_state", 32'(seq_state), 32'd3);
    checkOutput("pcierst_end_core_rst", 32'(pcie_core_rst), 32'd1);
    stepCycles(1);
    checkOutput("waitlink_state", 32'(seq_state), 32'd4);
    checkOutput("waitlink_core_rst", 32'(pcie_core_rst), 32'd0);
    checkOutput("waitlink_err", 32'(err_link_timeout), 32'd0);

    $display("[TB] link-up, config reload pulse and link loss");
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycles(1);
    checkOutput("run_state", 32'(seq_state), 32'd5);
    checkOutput("run_reload_first", 32'(rst_cfg_reload), 32'd1);
    stepCycles(1);
    checkOutput("run_reload_second", 32'(rst_cfg_reload), 32'd0);
    checkOutput("run_state_second", 32'(seq_state), 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("linkloss_state", 32'(seq_state), 32'd3);
    checkOutput("linkloss_core_rst", 32'(pcie_core_rst), 32'd1);
    stepCycles(15);
    checkOutput("linkloss_rst_end", 32'(seq_state), 32'd3);
    stepCycles(1);
    checkOutput("relink_waitlink", 32'(seq_state), 32'd4);

    $display("[TB] link timeout and retry");
    stepCycles(99);
    checkOutput("timeout_pre_state", 32'(seq_state), 32'd4);
    checkOutput("timeout_pre_err", 32'(err_link_timeout), 32'd0);
    stepCycles(1);
    checkOutput("timeout_state", 32'(seq_state), 32'd3);
    checkOutput("timeout_err", 32'(err_link_timeout), 32'd1);
    stepCycles(16);
    checkOutput("retry_waitlink", 32'(seq_state), 32'd4);
    stepCycles(100);
    checkOutput("retry2_state", 32'(seq_state), 32'd3);
    checkOutput("retry2_err", 32'(err_link_timeout), 32'd1);
    stepCycles(16);
    checkOutput("retry2_waitlink", 32'(seq_state), 32'd4);

    $display("[TB] PERST# priority over link loss and glitch rejection");
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycles(1);
    checkOutput("run2_state", 32'(seq_state), 32'd5);
    checkOutput("run2_reload", 32'(rst_cfg_reload), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(2);
    checkOutput("perst_sync_delay", 32'(seq_state), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("perst_priority_state", 32'(seq_state), 32'd2);
    checkOutput("perst_priority_core_rst", 32'(pcie_core_rst), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(500);
    checkOutput("glitch_hold", 32'(seq_state), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(10);
    checkOutput("glitch_low", 32'(seq_state), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(1025);
    checkOutput("clean_debounce_pre", 32'(seq_state), 32'd2);
    stepCycles(1);
    checkOutput("clean_debounce_done", 32'(seq_state), 32'd3);
    stepCycles(16);
    checkOutput("mid_waitlink_state", 32'(seq_state), 32'd4);
    stepCycles(5);
    checkOutput("mid_waitlink_err", 32'(err_link_timeout), 32'd1);

    $display("[TB] asynchronous reset mid WAIT_LINK");
    rst_n = 1'b0;
    #1;
    checkResetValues("async_rst");
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b1;
    stepCycles(64);
    checkOutput("restart_comup", 32'(seq_state), 32'd1);
    checkOutput("restart_rst_sys", 32'(rst_sys), 32'd0);
    stepCycles(1);
    checkOutput("restart_waitperst", 32'(seq_state), 32'd2);

    $display("[TB] WAKE# while present and held in PERST#");
    stepCycles(1024);
    checkOutput("wake_at_limit", 32'(pcie_wake_n), 32'd1);
    stepCycles(1);
    checkOutput("wake_past_limit", 32'(pcie_wake_n), 32'(wake_exp_low));
    checkOutput("wake_state", 32'(seq_state), 32'd2);
    stepCycles(10);
    checkOutput("wake_hold", 32'(pcie_wake_n), 32'(wake_exp_low));
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(2);
    checkOutput("wake_sync_delay", 32'(pcie_wake_n), 32'(wake_exp_low));
    stepCycles(1);
    checkOutput("wake_release", 32'(pcie_wake_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
